div_man: RTL and testbench

//   Pipelined unsigned restoring divider (shift-subtract), the inverse of the shift-add multiplier.

---
 rtl/div_man_pkg.sv | 7 +
 rtl/div_stage.sv | 56 +++++
 rtl/div_man.sv | 89 ++++++++
 tb/tb_div_man.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_man_pkg.sv
// Shared widths and latency for the pipelined restoring divider.
// Benches and the FIR top take DIV_N / DIV_M / DIV_LAT from here instead of literals.
package div_man_pkg;
  localparam int DIV_N   = 13;
  localparam int DIV_M   = 12;
  localparam int DIV_LAT = DIV_N;
endpackage

// File: rtl/div_stage.sv
// One restoring shift-subtract stage: resolves quotient bit K and registers the operation payload.
// Data registers load only when the upstream stage holds a valid operation; valid always shifts.
module div_stage #(
  parameter int N = 13,
  parameter int M = 12,
  parameter int K = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         up_valid,
  input  logic [M-1:0] up_r,
  input  logic [N-1:0] up_q,
  input  logic [N-1:0] up_dvd,
  input  logic [M-1:0] up_dsr,
  input  logic         up_zero,
  output logic         valid,
  output logic [M-1:0] r,
  output logic [N-1:0] q,
  output logic [N-1:0] dvd,
  output logic [M-1:0] dsr,
  output logic         zero
);

  logic [M:0]   trial;
  logic [M-1:0] diff;
  logic         ge;

  // The partial remainder is always below the divisor, so the M-bit difference is exact when ge.
  always_comb begin
    trial = {up_r, up_dvd[K]};
    ge    = trial >= {1'b0, up_dsr};
    diff  = trial[M-1:0] - up_dsr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      r     <= '0;
      q     <= '0;
      dvd   <= '0;
      dsr   <= '0;
      zero  <= 1'b0;
    end else begin
      valid <= up_valid;
      if (up_valid) begin
        r    <= ge ? diff : trial[M-1:0];
        q    <= up_q;
        q[K] <= ge;
        dvd  <= up_dvd;
        dsr  <= up_dsr;
        zero <= up_zero;
      end
    end
  end

endmodule

// File: rtl/div_man.sv
// Fully pipelined unsigned restoring divider: N stages, one result per clock, latency N.
// Define DIV_ZERO_FLAG_EN to expose the div_zero output flag.
module div_man
  import div_man_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         res_rdy,
  output logic [N-1:0] quo,
  output logic [M-1:0] rem
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic         div_zero
`endif
);

  // Index 0 is the input side, index k+1 is the output of stage k.
  logic [N:0]        v_s;
  logic [N:0][M-1:0] r_s;
  logic [N:0][N-1:0] q_s;
  logic [N:0][N-1:0] dvd_s;
  logic [N:0][M-1:0] dsr_s;
  logic [N:0]        z_s;
  logic              unused_tail;

  assign v_s[0]   = data_rdy;
  assign r_s[0]   = '0;
  assign q_s[0]   = '0;
  assign dvd_s[0] = dividend;
  assign dsr_s[0] = divisor;
  assign z_s[0]   = (divisor == '0);

  for (genvar k = 0; k < N; k++) begin : g_stage
    div_stage #(
      .N(N),
      .M(M),
      .K(N - 1 - k)
    ) u_stage (
      .clk     (clk),
      .rstn    (rstn),
      .up_valid(v_s[k]),
      .up_r    (r_s[k]),
      .up_q    (q_s[k]),
      .up_dvd  (dvd_s[k]),
      .up_dsr  (dsr_s[k]),
      .up_zero (z_s[k]),
      .valid   (v_s[k+1]),
      .r       (r_s[k+1]),
      .q       (q_s[k+1]),
      .dvd     (dvd_s[k+1]),
      .dsr     (dsr_s[k+1]),
      .zero    (z_s[k+1])
    );
  end

  // Divisor and upper dividend bits are carried to the end but only the low dividend bits are needed.
  assign unused_tail = ^{dsr_s[N], dvd_s[N]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_rdy <= 1'b0;
      quo     <= '0;
      rem     <= '0;
    end else begin
      res_rdy <= v_s[N];
      if (v_s[N]) begin
        quo <= z_s[N] ? '1 : q_s[N];
        rem <= z_s[N] ? dvd_s[N][M-1:0] : r_s[N];
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_zero <= 1'b0;
    end else begin
      div_zero <= v_s[N] & z_s[N];
    end
  end
`endif

endmodule

// File: tb/tb_div_man.sv
// Self-checking bench for div_man: directed vector table, streaming, bubbles and mid-flight reset.
// Expected results are tracked with a latency-N valid queue and an expected-result queue.
module tb_div_man;
  import div_man_pkg::*;

  localparam int N = DIV_N;
  localparam int M = DIV_M;
  localparam int W = 1 + N + M;

  logic         clk;
  logic         rstn;
  logic         data_rdy;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         res_rdy;
  logic [N-1:0] quo;
  logic [M-1:0] rem;
  logic         zero_obs;

  div_man #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .data_rdy(data_rdy),
    .dividend(dividend),
    .divisor (divisor),
    .res_rdy (res_rdy),
    .quo     (quo),
    .rem     (rem)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero(zero_obs)
`endif
  );

`ifndef DIV_ZERO_FLAG_EN
  assign zero_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         vq[$];
  logic [W-1:0] exp_q[$];
  logic [N-1:0] hold_quo;
  logic [M-1:0] hold_rem;

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input logic [N-1:0] a, input logic [M-1:0] b);
    int unsigned ai;
    int unsigned bi;
    logic [N-1:0] qq;
    logic [M-1:0] rr;
    ai = 32'(a);
    bi = 32'(b);
    if (bi == 0) return {1'b1, {N{1'b1}}, a[M-1:0]};
    qq = N'(ai / bi);
    rr = M'(ai % bi);
    return {1'b0, qq, rr};
  endfunction

  // driver: present one cycle of input, clock it, then compare against the model
  task automatic cycle(input logic v, input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [W-1:0] e);
    logic         er;
    logic         ez;
    logic [W-1:0] w;
    data_rdy = v;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    vq.push_back(v);
    if (v) exp_q.push_back(e);
    er = 1'b0;
    if (vq.size() > N) er = vq.pop_front();
    ez = 1'b0;
    if (er) begin
      w        = exp_q.pop_front();
      hold_quo = w[N+M-1:M];
      hold_rem = w[M-1:0];
      ez       = w[W-1];
    end
    check("res_rdy", 32'(res_rdy), 32'(er));
    check("quo", 32'(quo), 32'(hold_quo));
    check("rem", 32'(rem), 32'(hold_rem));
`ifdef DIV_ZERO_FLAG_EN
    check("div_zero", 32'(zero_obs), 32'(ez));
`endif
  endtask

  task automatic cycle_auto(input logic v, input logic [N-1:0] a, input logic [M-1:0] b);
    cycle(v, a, b, ref_div(a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_auto(1'b0, '0, '0);
  endtask

  task automatic model_clear();
    vq.delete();
    exp_q.delete();
    hold_quo = '0;
    hold_rem = '0;
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [6:0] pat;
    vecs[0] = '{a: 13'd100,  b: 12'd7,    q: 13'd14,   r: 12'd2,    z: 1'b0};
    vecs[1] = '{a: 13'd8191, b: 12'd1,    q: 13'd8191, r: 12'd0,    z: 1'b0};
    vecs[2] = '{a: 13'd8191, b: 12'd4095, q: 13'd2,    r: 12'd1,    z: 1'b0};
    vecs[3] = '{a: 13'd0,    b: 12'd4095, q: 13'd0,    r: 12'd0,    z: 1'b0};
    vecs[4] = '{a: 13'd4094, b: 12'd4095, q: 13'd0,    r: 12'd4094, z: 1'b0};
    vecs[5] = '{a: 13'd1000, b: 12'd10,   q: 13'd100,  r: 12'd0,    z: 1'b0};
    vecs[6] = '{a: 13'd1234, b: 12'd0,    q: 13'd8191, r: 12'd1234, z: 1'b1};
    vecs[7] = '{a: 13'd999,  b: 12'd9,    q: 13'd111,  r: 12'd0,    z: 1'b0};
    vecs[8] = '{a: 13'd4095, b: 12'd64,   q: 13'd63,   r: 12'd63,   z: 1'b0};
    vecs[9] = '{a: 13'd5000, b: 12'd3,    q: 13'd1666, r: 12'd2,    z: 1'b0};

    rstn     = 1'b0;
    data_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_res_rdy", 32'(res_rdy), 32'd0);
    check("reset_quo", 32'(quo), 32'd0);
    check("reset_rem", 32'(rem), 32'd0);
    check("reset_div_zero", 32'(zero_obs), 32'd0);
    rstn = 1'b1;

    // single operation: one pulse, result exactly N cycles later
    idle(2);
    cycle(1'b1, 13'd100, 12'd7, {1'b0, 13'd14, 12'd2});
    idle(N + 3);

    // directed table, issued back to back
    for (int i = 0; i < 10; i++)
      cycle(1'b1, vecs[i].a, vecs[i].b, {vecs[i].z, vecs[i].q, vecs[i].r});
    idle(N + 2);

    // streaming
    for (int i = 0; i <= 200; i++) cycle_auto(1'b1, N'(i), M'(i + 3));
    idle(N + 2);

    // bubbles
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) cycle_auto(pat[i], N'(300 + i * 37), M'(5 + i));
    idle(N + 2);

    // reset mid-flight: five operations, then a one-cycle reset pulse at cycle 6
    for (int i = 0; i < 5; i++) cycle_auto(1'b1, N'(2000 + i * 111), M'(13 + i));
    data_rdy = 1'b0;
    rstn     = 1'b0;
    #1;
    check("midreset_res_rdy", 32'(res_rdy), 32'd0);
    check("midreset_quo", 32'(quo), 32'd0);
    check("midreset_rem", 32'(rem), 32'd0);
    check("midreset_div_zero", 32'(zero_obs), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(N + 4);
    cycle(1'b1, 13'd7777, 12'd77, {1'b0, 13'd101, 12'd0});
    cycle(1'b1, 13'd6000, 12'd7, {1'b0, 13'd857, 12'd1});
    cycle_auto(1'b1, 13'd123, 12'd0);
    idle(N + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
